touch_adc_ctrl: RTL and testbench
=================================

TOUCH_ADC_CTRL -- requirements
Module: touch_adc_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 16, sys_clk cycles per DCLK half-period (minimum 2).
REQ-002 Parameter DEBOUNCE_CYC, default 1024, sys_clk cycles penirq_n must stay low before sampling starts.
REQ-003 Parameter SAMPLE_GAP, default 4096, idle sys_clk cycles between consecutive X/Y frame pairs while the pen is down.
REQ-004 sys_clk  in  1  system clock; the only clock.
REQ-005 iRST_n  in  1  reset, synchronous, active-low.
REQ-006 penirq_n  in  1  pen interrupt from the ADC (asynchronous; low = pen down).
REQ-007 adc_dout  in  1  ADC serial data out.
REQ-008 adc_cs_n / adc_dclk / adc_din  out  1 each  ADC chip select, serial clock, command data.
REQ-009 x / y  out  8  latest coordinate pair, MSB = ADC bit 7.
REQ-010 new_coord_r  out  1  one-cycle pulse when x/y update.
REQ-011 transmit_en  out  1  touch session active (pen down and sampling).

Function
REQ-012 penirq_n shall pass through a 2-flop synchronizer; only the synchronized value is used, and only while adc_cs_n is high.
REQ-013 FSM states: IDLE, DEBOUNCE, FRAME_X, FRAME_Y, PUBLISH, GAP.
REQ-014 IDLE -> DEBOUNCE on synchronized penirq_n low; DEBOUNCE -> IDLE if it goes high before DEBOUNCE_CYC counts, else -> FRAME_X.
REQ-015 transmit_en shall rise in the same cycle as entry to FRAME_X from DEBOUNCE, and fall on the cycle the FSM returns to IDLE.
REQ-016 Each frame: adc_cs_n low, 24 DCLK periods, adc_cs_n high for at least one DCLK half-period before the next frame; DCLK idles low.
REQ-017 adc_din shall change on DCLK falling edges (first bit valid before first rising edge), command MSB first on DCLK periods 1-8, then 0.
REQ-018 Commands: X = 8'hD8, Y = 8'h98 (start, channel, 8-bit mode, differential, power-down between conversions).
REQ-019 adc_dout shall be sampled on the sys_clk cycle of DCLK rising edges 10-17, MSB first, into an 8-bit shift register.
REQ-020 FRAME_X -> FRAME_Y -> PUBLISH; PUBLISH lasts one cycle, loads x/y and pulses new_coord_r, then -> GAP.
REQ-021 GAP counts SAMPLE_GAP cycles; at expiry penirq_n low -> FRAME_X, high -> IDLE.
REQ-022 Pen release during a frame pair: pair completes, PUBLISH is skipped, x/y unchanged, FSM -> IDLE.
REQ-023 x/y shall hold their values between new_coord_r pulses, including across sessions.
REQ-024 Divider and bit counters shall wrap exactly at CLK_DIV-1 and 47 (24 DCLK periods, two half-periods each) with no extra cycle.

Reset
REQ-025 While iRST_n is low at a sys_clk edge: FSM = IDLE, adc_cs_n = 1, adc_dclk = 0, adc_din = 0, x = y = 0, new_coord_r = 0, transmit_en = 0, all counters = 0.
REQ-026 Reset asserted mid-frame shall drive adc_cs_n high on that edge; no partial result is published.

Configuration
REQ-027 Macro TOUCH_AVG_EN: when defined, four consecutive valid pairs are accumulated in 10-bit sums and PUBLISH fires only on every fourth pair, with x/y = sum>>2. Pen release discards the partial accumulation.
REQ-028 Without TOUCH_AVG_EN, every valid pair is published directly and no accumulators exist.

Structure
REQ-029 Package touch_pkg shall hold the FSM state enum, CMD_X/CMD_Y constants and the frame-length constant (24).
REQ-030 One sub-module, touch_spi_frame, shall run a single 24-DCLK frame (start/done handshake, 8-bit command in, 8-bit result out); touch_adc_ctrl holds the FSM, timers and averaging.

Verification
REQ-031 penirq_n low 500 cycles then high (DEBOUNCE_CYC=1024) -> no frame, transmit_en stays 0.
REQ-032 Pen held, ADC model returns X=8'hA5, Y=8'h3C -> adc_din shows D8 then 98, x=8'hA5, y=8'h3C, one-cycle new_coord_r after the Y frame.
REQ-033 CLK_DIV=4 -> adc_cs_n low for exactly 192 sys_clk cycles per frame, DCLK period 8 cycles.
REQ-034 penirq_n released during FRAME_Y -> pair completes, no new_coord_r, x/y unchanged, transmit_en falls on return to IDLE.
REQ-035 iRST_n low at DCLK period 12 -> adc_cs_n high next edge, all outputs at reset values, fresh debounce required.
REQ-036 TOUCH_AVG_EN defined, X samples 10,11,12,13 -> single pulse with x=11.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared state encoding and ADS7843-style command constants for the touch-screen ADC controller.
package touch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_FRAME_X,
        ST_FRAME_Y,
        ST_PUBLISH,
        ST_GAP
    } touch_state_t;

    // start | channel | 8-bit mode | differential | power-down between conversions
    localparam logic [7:0] CMD_X = 8'hD8;
    localparam logic [7:0] CMD_Y = 8'h98;

    localparam int FRAME_DCLKS = 24;

endpackage

// File: rtl/touch_spi_frame.sv
// Runs one 24-DCLK serial frame: shifts the command out MSB first and captures the 8-bit result.
module touch_spi_frame
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       start,
    input  logic [7:0] cmd,
    input  logic       adc_dout,
    output logic       done,
    output logic [7:0] result,
    output logic       adc_cs_n,
    output logic       adc_dclk,
    output logic       adc_din
);

    localparam int         DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0] HALF_LAST = 6'(2 * FRAME_DCLKS - 1);
    // rising edges of DCLK periods 10..17 happen when leaving half-periods 18..32
    localparam logic [5:0] SMP_FIRST = 6'd18;
    localparam logic [5:0] SMP_LAST  = 6'd32;

    typedef enum logic [1:0] {SPI_IDLE, SPI_RUN, SPI_TAIL} spi_state_t;

    spi_state_t       spi_state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       half_cnt;
    logic [7:0]       cmd_sr;

    always_ff @(posedge sys_clk) begin
        if (!iRST_n) begin
            spi_state <= SPI_IDLE;
            div_cnt   <= '0;
            half_cnt  <= '0;
            cmd_sr    <= '0;
            result    <= '0;
            done      <= 1'b0;
            adc_cs_n  <= 1'b1;
            adc_dclk  <= 1'b0;
            adc_din   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (spi_state)
                SPI_IDLE: begin
                    if (start) begin
                        spi_state <= SPI_RUN;
                        adc_cs_n  <= 1'b0;
                        adc_din   <= cmd[7];
                        cmd_sr    <= {cmd[6:0], 1'b0};
                        div_cnt   <= '0;
                        half_cnt  <= '0;
                    end
                end
                SPI_RUN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (half_cnt == HALF_LAST) begin
                            half_cnt  <= '0;
                            spi_state <= SPI_TAIL;
                            adc_cs_n  <= 1'b1;
                            adc_dclk  <= 1'b0;
                            adc_din   <= 1'b0;
                        end else begin
                            half_cnt <= half_cnt + 6'd1;
                            adc_dclk <= ~half_cnt[0];
                            if (!half_cnt[0]) begin
                                if (half_cnt >= SMP_FIRST && half_cnt <= SMP_LAST)
                                    result <= {result[6:0], adc_dout};
                            end else begin
                                adc_din <= cmd_sr[7];
                                cmd_sr  <= {cmd_sr[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_TAIL: begin
                    // hold chip select high for a half-period before allowing the next frame
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        spi_state <= SPI_IDLE;
                        done      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: spi_state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/touch_adc_ctrl.sv
// Touch-screen ADC sequencer: debounces pen-down, reads X/Y frame pairs, publishes coordinates.
// Define TOUCH_AVG_EN to publish the average of every four consecutive valid pairs.
//
// state    | meaning
// IDLE     | pen up, waiting for synchronized pen-down
// DEBOUNCE | pen must stay down DEBOUNCE_CYC cycles
// FRAME_X  | X conversion frame in progress
// FRAME_Y  | Y conversion frame in progress
// PUBLISH  | one cycle: load x/y, pulse new_coord_r
// GAP      | idle SAMPLE_GAP cycles before the next pair
module touch_adc_ctrl
    import touch_pkg::*;
#(
    parameter int CLK_DIV      = 16,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int SAMPLE_GAP   = 4096
) (
    input  logic       sys_clk,
    input  logic       iRST_n,
    input  logic       penirq_n,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_dclk,
    output logic       adc_din,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       new_coord_r,
    output logic       transmit_en
);

    localparam int TMR_MAX = (DEBOUNCE_CYC > SAMPLE_GAP) ? DEBOUNCE_CYC : SAMPLE_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] DEB_LOAD = TMR_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(SAMPLE_GAP - 1);

    touch_state_t state;
    logic [TMR_W-1:0] tmr;
    logic             penirq_meta, penirq_sync, pen_down, pen_lost;
    logic             spi_start, spi_done;
    logic [7:0]       spi_cmd, spi_result, x_smp;
`ifdef TOUCH_AVG_EN
    logic [9:0]       sum_x, sum_y;
    logic [1:0]       avg_cnt;
`endif

    assign spi_cmd = (state == ST_FRAME_Y) ? CMD_Y : CMD_X;

    touch_spi_frame #(.CLK_DIV(CLK_DIV)) u_frame (
        .sys_clk  (sys_clk),
        .iRST_n   (iRST_n),
        .start    (spi_start),
        .cmd      (spi_cmd),
        .adc_dout (adc_dout),
        .done     (spi_done),
        .result   (spi_result),
        .adc_cs_n (adc_cs_n),
        .adc_dclk (adc_dclk),
        .adc_din  (adc_din)
    );

    always_ff @(posedge sys_clk) begin
        if (!iRST_n) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            penirq_meta <= 1'b1;
            penirq_sync <= 1'b1;
            pen_down    <= 1'b0;
            pen_lost    <= 1'b0;
            spi_start   <= 1'b0;
            x_smp       <= '0;
            x           <= '0;
            y           <= '0;
            new_coord_r <= 1'b0;
            transmit_en <= 1'b0;
`ifdef TOUCH_AVG_EN
            sum_x       <= '0;
            sum_y       <= '0;
            avg_cnt     <= '0;
`endif
        end else begin
            penirq_meta <= penirq_n;
            penirq_sync <= penirq_meta;
            // the ADC disturbs PENIRQ while converting, so only trust it with CS high
            if (adc_cs_n)
                pen_down <= ~penirq_sync;
            spi_start   <= 1'b0;
            new_coord_r <= 1'b0;
            case (state)
                ST_IDLE: begin
`ifdef TOUCH_AVG_EN
                    sum_x   <= '0;
                    sum_y   <= '0;
                    avg_cnt <= '0;
`endif
                    if (pen_down) begin
                        state <= ST_DEBOUNCE;
                        tmr   <= DEB_LOAD;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!pen_down) begin
                        state <= ST_IDLE;
                    end else if (tmr == '0) begin
                        state       <= ST_FRAME_X;
                        spi_start   <= 1'b1;
                        transmit_en <= 1'b1;
                        pen_lost    <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_FRAME_X: begin
                    if (!pen_down)
                        pen_lost <= 1'b1;
                    if (spi_done) begin
                        x_smp     <= spi_result;
                        state     <= ST_FRAME_Y;
                        spi_start <= 1'b1;
                    end
                end
                ST_FRAME_Y: begin
                    if (!pen_down)
                        pen_lost <= 1'b1;
                    if (spi_done) begin
                        if (!pen_down || pen_lost) begin
                            state       <= ST_IDLE;
                            transmit_en <= 1'b0;
                        end else begin
`ifdef TOUCH_AVG_EN
                            sum_x   <= sum_x + {2'b00, x_smp};
                            sum_y   <= sum_y + {2'b00, spi_result};
                            avg_cnt <= avg_cnt + 2'd1;
                            if (avg_cnt == 2'd3) begin
                                state <= ST_PUBLISH;
                            end else begin
                                state <= ST_GAP;
                                tmr   <= GAP_LOAD;
                            end
`else
                            state <= ST_PUBLISH;
`endif
                        end
                    end
                end
                ST_PUBLISH: begin
`ifdef TOUCH_AVG_EN
                    x     <= sum_x[9:2];
                    y     <= sum_y[9:2];
                    sum_x <= '0;
                    sum_y <= '0;
`else
                    x     <= x_smp;
                    y     <= spi_result;
`endif
                    new_coord_r <= 1'b1;
                    state       <= ST_GAP;
                    tmr         <= GAP_LOAD;
                end
                ST_GAP: begin
                    if (tmr == '0) begin
                        if (pen_down) begin
                            state     <= ST_FRAME_X;
                            spi_start <= 1'b1;
                            pen_lost  <= 1'b0;
                        end else begin
                            state       <= ST_IDLE;
                            transmit_en <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Directed bench for touch_adc_ctrl with a bit-level ADC model; honours TOUCH_AVG_EN when defined.
module tb_touch_adc_ctrl;

    localparam int CLK_DIV = 4;
    localparam int DEB     = 1024;
    localparam int GAP     = 64;
`ifdef TOUCH_AVG_EN
    localparam int PAIRS = 4;
`else
    localparam int PAIRS = 1;
`endif

    logic       sys_clk  = 1'b0;
    logic       iRST_n   = 1'b0;
    logic       penirq_n = 1'b1;
    logic       adc_dout = 1'b0;
    logic       adc_cs_n, adc_dclk, adc_din, new_coord_r, transmit_en;
    logic [7:0] x, y;

    touch_adc_ctrl #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYC(DEB), .SAMPLE_GAP(GAP)) dut (
        .sys_clk     (sys_clk),
        .iRST_n      (iRST_n),
        .penirq_n    (penirq_n),
        .adc_dout    (adc_dout),
        .adc_cs_n    (adc_cs_n),
        .adc_dclk    (adc_dclk),
        .adc_din     (adc_din),
        .x           (x),
        .y           (y),
        .new_coord_r (new_coord_r),
        .transmit_en (transmit_en)
    );

    always #5 sys_clk = ~sys_clk;

    // ADC model and observers, evaluated on the falling sys_clk edge
    int         cyc = 0, frame_cnt = 0, pulse_cnt = 0, te_cnt = 0;
    int         rise_cnt = 0, cs_low_cnt = 0, last_cs_low = 0, last_rise_cyc = 0, dclk_per = 0;
    logic       prev_dclk = 1'b0, prev_cs = 1'b1;
    logic [7:0] cmd_cap = 8'h00, cur_data = 8'h00;
    logic [7:0] cmd_log[$];
    logic [1:0] x_idx = 2'd0, y_idx = 2'd0;
    logic [7:0] x_tab[4];
    logic [7:0] y_tab[4];

    always @(negedge sys_clk) begin
        cyc++;
        if (!iRST_n) begin
            x_idx = 2'd0;
            y_idx = 2'd0;
        end
        if (new_coord_r) pulse_cnt++;
        if (transmit_en) te_cnt++;
        if (prev_cs && !adc_cs_n) begin
            frame_cnt++;
            rise_cnt   = 0;
            cmd_cap    = 8'h00;
            cs_low_cnt = 0;
        end
        if (!adc_cs_n) cs_low_cnt++;
        if (!prev_cs && adc_cs_n) last_cs_low = cs_low_cnt;
        if (!adc_cs_n && !prev_dclk && adc_dclk) begin
            rise_cnt++;
            dclk_per      = cyc - last_rise_cyc;
            last_rise_cyc = cyc;
            if (rise_cnt <= 8) cmd_cap = {cmd_cap[6:0], adc_din};
            if (rise_cnt == 8) begin
                cmd_log.push_back(cmd_cap);
                if (cmd_cap == 8'hD8) begin
                    cur_data = x_tab[x_idx];
                    x_idx++;
                end else begin
                    cur_data = y_tab[y_idx];
                    y_idx++;
                end
            end
        end
        if (!adc_cs_n && prev_dclk && !adc_dclk)
            adc_dout = (rise_cnt >= 9 && rise_cnt <= 16) ? cur_data[16 - rise_cnt] : 1'b0;
        prev_dclk = adc_dclk;
        prev_cs   = adc_cs_n;
    end

    int tests_run = 0;
    int fails     = 0;

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_pulse(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (new_coord_r) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_te_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!transmit_en) break;
        end
    endtask

    task automatic set_tabs(input logic [7:0] xv, input logic [7:0] yv);
        for (int i = 0; i < 4; i++) begin
            x_tab[i] = xv;
            y_tab[i] = yv;
        end
    endtask

    initial begin
        int f0, p0, te0, base, t0;
        bit ok;
        set_tabs(8'hA5, 8'h3C);

        // reset values
        iRST_n   = 1'b0;
        penirq_n = 1'b1;
        repeat (5) tick();
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_dclk", adc_dclk, 0);
        chk("rst_din", adc_din, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_new_coord", new_coord_r, 0);
        chk("rst_transmit_en", transmit_en, 0);
        iRST_n = 1'b1;
        repeat (10) tick();

        // short pen-down bounce: no frame, no session
        f0 = frame_cnt; te0 = te_cnt;
        penirq_n = 1'b0;
        repeat (500) tick();
        penirq_n = 1'b1;
        repeat (600) tick();
        chk("bounce_frames", frame_cnt - f0, 0);
        chk("bounce_transmit_en", te_cnt - te0, 0);

        // held pen, X=A5 Y=3C
        f0 = frame_cnt; base = cmd_log.size(); t0 = cyc;
        penirq_n = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (transmit_en) break;
        end
        chk("te_after_debounce", ((cyc - t0) >= DEB && (cyc - t0) <= DEB + 6), 1);
        chk("no_frame_before_te", frame_cnt - f0, 0);
        wait_pulse(8000, ok);
        chk("pulse_seen", ok, 1);
        chk("x_value", x, 8'hA5);
        chk("y_value", y, 8'h3C);
        chk("frames_per_pulse", frame_cnt - f0, 2 * PAIRS);
        chk("cmd_first_x", cmd_log[base], 8'hD8);
        chk("cmd_then_y", cmd_log[base + 1], 8'h98);
        chk("cs_high_at_pulse", adc_cs_n, 1);
        chk("cs_low_cycles", last_cs_low, 48 * CLK_DIV);
        chk("dclk_period", dclk_per, 2 * CLK_DIV);
        tick();
        chk("pulse_one_cycle", new_coord_r, 0);
        chk("te_in_session", transmit_en, 1);

        // release during the Y frame: pair completes, nothing published
        set_tabs(8'h11, 8'h22);
        base = cmd_log.size(); p0 = pulse_cnt;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (cmd_log.size() >= base + 2) break;
        end
        chk("reached_y_frame", (cmd_log.size() >= base + 2), 1);
        chk("release_in_y_cs_low", adc_cs_n, 0);
        f0 = frame_cnt;
        penirq_n = 1'b1;
        wait_te_low(2000);
        chk("release_te_low", transmit_en, 0);
        chk("release_cs_high", adc_cs_n, 1);
        chk("release_y_completed", last_cs_low, 48 * CLK_DIV);
        repeat (300) tick();
        chk("release_no_pulse", pulse_cnt - p0, 0);
        chk("release_no_new_frame", frame_cnt - f0, 0);
        chk("release_x_hold", x, 8'hA5);
        chk("release_y_hold", y, 8'h3C);

        // reset in DCLK period 12 of a frame
        set_tabs(8'h5A, 8'hC3);
        penirq_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!adc_cs_n && rise_cnt == 12) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reached_period_12", ok, 1);
        iRST_n = 1'b0;
        tick();
        chk("midrst_cs_n", adc_cs_n, 1);
        chk("midrst_dclk", adc_dclk, 0);
        chk("midrst_din", adc_din, 0);
        chk("midrst_x", x, 0);
        chk("midrst_y", y, 0);
        chk("midrst_new_coord", new_coord_r, 0);
        chk("midrst_transmit_en", transmit_en, 0);
        tick();
        iRST_n = 1'b1;
        f0 = frame_cnt; p0 = pulse_cnt;
        repeat (1000) tick();
        chk("midrst_fresh_debounce", frame_cnt - f0, 0);
        chk("midrst_no_pulse", pulse_cnt - p0, 0);
        wait_pulse(8000, ok);
        chk("after_rst_pulse", ok, 1);
        chk("after_rst_x", x, 8'h5A);
        chk("after_rst_y", y, 8'hC3);
        penirq_n = 1'b1;
        wait_te_low(4000);
        chk("after_rst_te_low", transmit_en, 0);

`ifdef TOUCH_AVG_EN
        // four pairs averaged into one publication
        iRST_n = 1'b0;
        repeat (3) tick();
        iRST_n = 1'b1;
        repeat (5) tick();
        x_tab[0] = 8'd10; x_tab[1] = 8'd11; x_tab[2] = 8'd12; x_tab[3] = 8'd13;
        y_tab[0] = 8'd20; y_tab[1] = 8'd24; y_tab[2] = 8'd28; y_tab[3] = 8'd32;
        f0 = frame_cnt; p0 = pulse_cnt;
        penirq_n = 1'b0;
        wait_pulse(8000, ok);
        chk("avg_pulse", ok, 1);
        chk("avg_x", x, 8'd11);
        chk("avg_y", y, 8'd26);
        chk("avg_single_pulse", pulse_cnt - p0, 1);
        chk("avg_frames", frame_cnt - f0, 8);
        penirq_n = 1'b1;
        wait_te_low(4000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
